// File: rtl/div10_pkg.sv
// ============================================================================
// Module   : div10_pkg
// Purpose  : Shared types and constants for the 10-bit sequential divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package div10_pkg;

   localparam int DW    = 10;
   localparam int ITER  = 10;
   localparam int CNT_W = 4;

   localparam logic [DW-1:0]    DIVZ_Q   = 10'h3FF;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/sub10bit.sv
// ============================================================================
// Module   : sub10bit
// Purpose  : 10-bit ripple subtractor, dif = a - b - bin with borrow out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sub10bit (
   input  logic [9:0] a,
   input  logic [9:0] b,
   input  logic       bin,
   output logic [9:0] dif,
   output logic       bout
);

   logic [10:0] diff_w;

   // Zero-extended subtraction; bit 10 is the borrow out of the 10-bit result.
   assign diff_w = {1'b0, a} - {1'b0, b} - {10'd0, bin};
   assign dif    = diff_w[9:0];
   assign bout   = diff_w[10];

endmodule

`default_nettype wire

// File: rtl/div10_seq.sv
// ============================================================================
// Module   : div10_seq
// Purpose  : 10-bit unsigned restoring divider, one quotient bit per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div10_seq
   import div10_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [DW-1:0] divisor,
   output logic          ready,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] quotient,
   output logic [DW-1:0] remainder,
   output logic          div_by_zero
);

   state_t state_q, state_d;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DW-1:0]    q_q, q_d;
   logic [DW-1:0]    r_q, r_d;
   logic [DW-1:0]    d_q, d_d;
   logic [DW-1:0]    quot_q, quot_d;
   logic [DW-1:0]    rem_q, rem_d;
   logic             dbz_q, dbz_d;

   logic [DW-1:0]    shift_rem;
   logic             rem_msb;
   logic [DW-1:0]    sub_dif;
   logic             sub_bout;
   logic             take;
   logic [DW-1:0]    r_step;
   logic [DW-1:0]    q_step;
   logic             accept;
   logic             last_iter;

   assign shift_rem = {r_q[DW-2:0], q_q[DW-1]};
   assign rem_msb   = r_q[DW-1];

   sub10bit u_sub (
      .a    (shift_rem),
      .b    (d_q),
      .bin  (1'b0),
      .dif  (sub_dif),
      .bout (sub_bout)
   );

   // A set bit shifted out of R means the 11-bit partial remainder exceeds D,
   // so the trial subtraction succeeds regardless of the 10-bit borrow.
   assign take      = rem_msb | ~sub_bout;
   assign r_step    = take ? sub_dif : shift_rem;
   assign q_step    = {q_q[DW-2:0], take};
   assign accept    = (state_q == IDLE) && start;
   assign last_iter = (cnt_q == LAST_CNT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         d_q     <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         r_q     <= r_d;
         d_q     <= d_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (start) state_d = (divisor == '0) ? DONE : RUN;
         RUN:  if (last_iter) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ready = (state_q == IDLE);
      busy  = (state_q == RUN);
      done  = (state_q == DONE);
   end

   always_comb begin
      cnt_d  = cnt_q;
      q_d    = q_q;
      r_d    = r_q;
      d_d    = d_q;
      quot_d = quot_q;
      rem_d  = rem_q;
      dbz_d  = dbz_q;
      if (accept) begin
         q_d   = dividend;
         d_d   = divisor;
         r_d   = '0;
         cnt_d = '0;
         dbz_d = 1'b0;
         if (divisor == '0) begin
            quot_d = DIVZ_Q;
            rem_d  = dividend;
            dbz_d  = 1'b1;
         end
      end else if (state_q == RUN) begin
         q_d   = q_step;
         r_d   = r_step;
         cnt_d = cnt_q + 1'b1;
         if (last_iter) begin
            quot_d = q_step;
            rem_d  = r_step;
         end
      end
   end

   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_div10_seq.sv
// ============================================================================
// Module   : tb_div10_seq
// Purpose  : Directed-vector and random self-checking bench for div10_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div10_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [9:0] dividend;
   logic [9:0] divisor;
   logic       ready;
   logic       busy;
   logic       done;
   logic [9:0] quotient;
   logic [9:0] remainder;
   logic       div_by_zero;

   int checks = 0;
   int errors = 0;
   int dbl_done = 0;
   logic done_prev = 1'b0;

   always #5 clk = ~clk;

   div10_seq dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .ready       (ready),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always @(negedge clk) begin
      if (done && done_prev) dbl_done++;
      done_prev <= done;
   end

   typedef struct {
      logic [9:0] dvd;
      logic [9:0] dvs;
      logic [9:0] exp_q;
      logic [9:0] exp_r;
      logic       exp_z;
      int         exp_lat;
      int         exp_busy;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // lat = rising edges after the accept edge until done is visible.
   task automatic do_div(input logic [9:0] dvd, input logic [9:0] dvs,
                         output logic [9:0] q, output logic [9:0] r,
                         output logic z, output int lat, output int bcnt);
      int n;
      n = 0;
      while (!ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("ready_before_start", int'(ready), 1);
      dividend = dvd;
      divisor  = dvs;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat  = 0;
      bcnt = 0;
      while (!done && lat < 40) begin
         if (busy) bcnt++;
         @(negedge clk);
         lat++;
      end
      q = quotient;
      r = remainder;
      z = div_by_zero;
   endtask

   initial begin
      logic [9:0] q, r, a, b;
      logic       z;
      int         lat, bcnt, npulse;

      vecs.push_back('{10'd100,  10'd7,    10'd14,   10'd2,    1'b0, 10, 10});
      vecs.push_back('{10'd1023, 10'd600,  10'd1,    10'd423,  1'b0, 10, 10});
      vecs.push_back('{10'd1023, 10'd1,    10'd1023, 10'd0,    1'b0, 10, 10});
      vecs.push_back('{10'd5,    10'd10,   10'd0,    10'd5,    1'b0, 10, 10});
      vecs.push_back('{10'd1023, 10'd1023, 10'd1,    10'd0,    1'b0, 10, 10});
      vecs.push_back('{10'd1000, 10'd0,    10'h3FF,  10'd1000, 1'b1, 0,  0});
      vecs.push_back('{10'd20,   10'd4,    10'd5,    10'd0,    1'b0, 10, 10});
      vecs.push_back('{10'd0,    10'd5,    10'd0,    10'd0,    1'b0, 10, 10});
      vecs.push_back('{10'd512,  10'd513,  10'd0,    10'd512,  1'b0, 10, 10});
      vecs.push_back('{10'd1022, 10'd1023, 10'd0,    10'd1022, 1'b0, 10, 10});

      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", int'(ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_quotient", int'(quotient), 0);
      chk("rst_remainder", int'(remainder), 0);
      chk("rst_dbz", int'(div_by_zero), 0);
      rst = 1'b0;
      @(negedge clk);

      foreach (vecs[i]) begin
         do_div(vecs[i].dvd, vecs[i].dvs, q, r, z, lat, bcnt);
         chk($sformatf("vec%0d_quotient", i), int'(q), int'(vecs[i].exp_q));
         chk($sformatf("vec%0d_remainder", i), int'(r), int'(vecs[i].exp_r));
         chk($sformatf("vec%0d_dbz", i), int'(z), int'(vecs[i].exp_z));
         chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
         chk($sformatf("vec%0d_busy_cycles", i), bcnt, vecs[i].exp_busy);
      end

      // Results must hold after the done pulse.
      do_div(10'd100, 10'd7, q, r, z, lat, bcnt);
      repeat (2) @(negedge clk);
      chk("hold_done_low", int'(done), 0);
      chk("hold_quotient", int'(quotient), 14);
      chk("hold_remainder", int'(remainder), 2);

      // Start while RUN is ignored.
      dividend = 10'd200; divisor = 10'd9; start = 1'b1;
      @(negedge clk);
      dividend = 10'd50; divisor = 10'd3;
      @(negedge clk);
      start = 1'b0;
      npulse = 0;
      for (int k = 0; k < 16; k++) begin
         if (done) npulse++;
         @(negedge clk);
      end
      chk("ignored_start_quotient", int'(quotient), 22);
      chk("ignored_start_remainder", int'(remainder), 2);
      chk("ignored_start_done_pulses", npulse, 1);

      // Reset mid-RUN after 5 iterations.
      dividend = 10'd300; divisor = 10'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      chk("midrun_busy_before_rst", int'(busy), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("midrun_rst_ready", int'(ready), 1);
      chk("midrun_rst_busy", int'(busy), 0);
      chk("midrun_rst_done", int'(done), 0);
      chk("midrun_rst_quotient", int'(quotient), 0);
      chk("midrun_rst_remainder", int'(remainder), 0);
      chk("midrun_rst_dbz", int'(div_by_zero), 0);
      rst = 1'b0;
      npulse = 0;
      for (int k = 0; k < 12; k++) begin
         if (done) npulse++;
         @(negedge clk);
      end
      chk("midrun_rst_no_done", npulse, 0);
      do_div(10'd300, 10'd7, q, r, z, lat, bcnt);
      chk("after_rst_quotient", int'(q), 42);
      chk("after_rst_remainder", int'(r), 6);
      chk("after_rst_latency", lat, 10);

      // Random sweep against the language operators.
      for (int k = 0; k < 2000; k++) begin
         a = 10'($urandom_range(0, 1023));
         b = 10'($urandom_range(1, 1023));
         do_div(a, b, q, r, z, lat, bcnt);
         if (q !== a / b || r !== a % b || z !== 1'b0 || lat != 10) begin
            errors++;
            $display("FAIL rand_%0d: %0d/%0d got q=%0d r=%0d z=%0d lat=%0d expected q=%0d r=%0d z=0 lat=10",
                     k, a, b, q, r, z, lat, a / b, a % b);
         end
         checks++;
      end

      @(negedge clk);
      chk("done_never_back_to_back", dbl_done, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
